axi_txn_arbiter: RTL

- Transaction-locked 2:1 AXI4 arbiter. Shares the single io_master port between the IFU and the LSU/EXU.
- Replaces combinational valid-priority muxing with a registered owner/direction FSM. Grant is held from address acceptance until the transaction completes.
- Adds round-robin fairness and a watchdog that reports a hung transaction.

---
 rtl/axi_txn_arbiter_pkg.sv | 64 ++++++
 rtl/axi_chan_mux.sv | 62 ++++++
 rtl/axi_txn_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_txn_arbiter_pkg.sv
// Shared types for the transaction-locked 2:1 AXI4 arbiter: FSM/direction
// encodings, master indices and packed request/response channel bundles.
package axi_txn_arbiter_pkg;

  localparam int ADDR_W  = 32;
  localparam int ID_W    = 4;
  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int DATA_W  = 64;
  localparam int STRB_W  = 8;
  localparam int RESP_W  = 2;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
  typedef enum logic {READ = 1'b0, WRITE = 1'b1} dir_e;

  localparam logic IFU = 1'b0;
  localparam logic EXU = 1'b1;

  // Everything a master drives toward the slave
  typedef struct packed {
    logic               awvalid;
    logic [ADDR_W-1:0]  awaddr;
    logic [ID_W-1:0]    awid;
    logic [LEN_W-1:0]   awlen;
    logic [SIZE_W-1:0]  awsize;
    logic [BURST_W-1:0] awburst;
    logic               wvalid;
    logic [DATA_W-1:0]  wdata;
    logic [STRB_W-1:0]  wstrb;
    logic               wlast;
    logic               bready;
    logic               arvalid;
    logic [ADDR_W-1:0]  araddr;
    logic [ID_W-1:0]    arid;
    logic [LEN_W-1:0]   arlen;
    logic [SIZE_W-1:0]  arsize;
    logic [BURST_W-1:0] arburst;
    logic               rready;
  } axi_req_t;

  // Everything the slave drives back toward a master
  typedef struct packed {
    logic               awready;
    logic               wready;
    logic               bvalid;
    logic [ID_W-1:0]    bid;
    logic [RESP_W-1:0]  bresp;
    logic               arready;
    logic               rvalid;
    logic [ID_W-1:0]    rid;
    logic [DATA_W-1:0]  rdata;
    logic [RESP_W-1:0]  rresp;
    logic               rlast;
  } axi_rsp_t;

  // Tie goes to whichever master did not win last time
  function automatic logic pick_winner(input logic req_ifu, input logic req_exu,
                                       input logic rr_last);
    if (req_ifu && req_exu) return ~rr_last;
    return req_exu;
  endfunction

endpackage

// File: rtl/axi_chan_mux.sv
// Combinational 2:1 request mux and response demux; only the owner's channels
// for the locked direction are connected, everything else is held at zero.
module axi_chan_mux
  import axi_txn_arbiter_pkg::*;
(
  input  logic     busy_i,
  input  logic     owner_i,
  input  dir_e     dir_i,
  input  axi_req_t ifu_req_i,
  input  axi_req_t exu_req_i,
  input  axi_rsp_t mst_rsp_i,
  output axi_req_t mst_req_o,
  output axi_rsp_t ifu_rsp_o,
  output axi_rsp_t exu_rsp_o
);

  axi_req_t sel_req;
  axi_rsp_t gated_rsp;

  always_comb begin
    sel_req   = (owner_i == EXU) ? exu_req_i : ifu_req_i;
    mst_req_o = '0;
    gated_rsp = '0;
    if (busy_i) begin
      if (dir_i == READ) begin
        mst_req_o.arvalid = sel_req.arvalid;
        mst_req_o.araddr  = sel_req.araddr;
        mst_req_o.arid    = sel_req.arid;
        mst_req_o.arlen   = sel_req.arlen;
        mst_req_o.arsize  = sel_req.arsize;
        mst_req_o.arburst = sel_req.arburst;
        mst_req_o.rready  = sel_req.rready;
        gated_rsp.arready = mst_rsp_i.arready;
        gated_rsp.rvalid  = mst_rsp_i.rvalid;
        gated_rsp.rid     = mst_rsp_i.rid;
        gated_rsp.rdata   = mst_rsp_i.rdata;
        gated_rsp.rresp   = mst_rsp_i.rresp;
        gated_rsp.rlast   = mst_rsp_i.rlast;
      end else begin
        mst_req_o.awvalid = sel_req.awvalid;
        mst_req_o.awaddr  = sel_req.awaddr;
        mst_req_o.awid    = sel_req.awid;
        mst_req_o.awlen   = sel_req.awlen;
        mst_req_o.awsize  = sel_req.awsize;
        mst_req_o.awburst = sel_req.awburst;
        mst_req_o.wvalid  = sel_req.wvalid;
        mst_req_o.wdata   = sel_req.wdata;
        mst_req_o.wstrb   = sel_req.wstrb;
        mst_req_o.wlast   = sel_req.wlast;
        mst_req_o.bready  = sel_req.bready;
        gated_rsp.awready = mst_rsp_i.awready;
        gated_rsp.wready  = mst_rsp_i.wready;
        gated_rsp.bvalid  = mst_rsp_i.bvalid;
        gated_rsp.bid     = mst_rsp_i.bid;
        gated_rsp.bresp   = mst_rsp_i.bresp;
      end
    end
    ifu_rsp_o = (busy_i && owner_i == IFU) ? gated_rsp : '0;
    exu_rsp_o = (busy_i && owner_i == EXU) ? gated_rsp : '0;
  end

endmodule

// File: rtl/axi_txn_arbiter.sv
// Transaction-locked 2:1 AXI4 arbiter (IFU/EXU -> io_master) with round-robin
// tie breaking and a watchdog that abandons a hung transaction.
module axi_txn_arbiter
  import axi_txn_arbiter_pkg::*;
#(
  parameter int unsigned TO_CYCLES = 4096,
  parameter int unsigned TO_W      = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  // IFU slave-side port
  input  logic        ifu_awvalid,
  output logic        ifu_awready,
  input  logic [31:0] ifu_awaddr,
  input  logic [3:0]  ifu_awid,
  input  logic [7:0]  ifu_awlen,
  input  logic [2:0]  ifu_awsize,
  input  logic [1:0]  ifu_awburst,
  input  logic        ifu_wvalid,
  output logic        ifu_wready,
  input  logic [63:0] ifu_wdata,
  input  logic [7:0]  ifu_wstrb,
  input  logic        ifu_wlast,
  output logic        ifu_bvalid,
  input  logic        ifu_bready,
  output logic [1:0]  ifu_bresp,
  output logic [3:0]  ifu_bid,
  input  logic        ifu_arvalid,
  output logic        ifu_arready,
  input  logic [31:0] ifu_araddr,
  input  logic [3:0]  ifu_arid,
  input  logic [7:0]  ifu_arlen,
  input  logic [2:0]  ifu_arsize,
  input  logic [1:0]  ifu_arburst,
  output logic        ifu_rvalid,
  input  logic        ifu_rready,
  output logic [63:0] ifu_rdata,
  output logic [1:0]  ifu_rresp,
  output logic        ifu_rlast,
  output logic [3:0]  ifu_rid,
  // EXU slave-side port
  input  logic        exu_awvalid,
  output logic        exu_awready,
  input  logic [31:0] exu_awaddr,
  input  logic [3:0]  exu_awid,
  input  logic [7:0]  exu_awlen,
  input  logic [2:0]  exu_awsize,
  input  logic [1:0]  exu_awburst,
  input  logic        exu_wvalid,
  output logic        exu_wready,
  input  logic [63:0] exu_wdata,
  input  logic [7:0]  exu_wstrb,
  input  logic        exu_wlast,
  output logic        exu_bvalid,
  input  logic        exu_bready,
  output logic [1:0]  exu_bresp,
  output logic [3:0]  exu_bid,
  input  logic        exu_arvalid,
  output logic        exu_arready,
  input  logic [31:0] exu_araddr,
  input  logic [3:0]  exu_arid,
  input  logic [7:0]  exu_arlen,
  input  logic [2:0]  exu_arsize,
  input  logic [1:0]  exu_arburst,
  output logic        exu_rvalid,
  input  logic        exu_rready,
  output logic [63:0] exu_rdata,
  output logic [1:0]  exu_rresp,
  output logic        exu_rlast,
  output logic [3:0]  exu_rid,
  // Downstream master port
  output logic        io_master_awvalid,
  input  logic        io_master_awready,
  output logic [31:0] io_master_awaddr,
  output logic [3:0]  io_master_awid,
  output logic [7:0]  io_master_awlen,
  output logic [2:0]  io_master_awsize,
  output logic [1:0]  io_master_awburst,
  output logic        io_master_wvalid,
  input  logic        io_master_wready,
  output logic [63:0] io_master_wdata,
  output logic [7:0]  io_master_wstrb,
  output logic        io_master_wlast,
  input  logic        io_master_bvalid,
  output logic        io_master_bready,
  input  logic [1:0]  io_master_bresp,
  input  logic [3:0]  io_master_bid,
  output logic        io_master_arvalid,
  input  logic        io_master_arready,
  output logic [31:0] io_master_araddr,
  output logic [3:0]  io_master_arid,
  output logic [7:0]  io_master_arlen,
  output logic [2:0]  io_master_arsize,
  output logic [1:0]  io_master_arburst,
  input  logic        io_master_rvalid,
  output logic        io_master_rready,
  input  logic [63:0] io_master_rdata,
  input  logic [1:0]  io_master_rresp,
  input  logic        io_master_rlast,
  input  logic [3:0]  io_master_rid,
  // Status
  output logic        owner,
  output logic        busy,
  output logic        to_err
);

  localparam logic WD_EN = (TO_CYCLES != 0);

  axi_req_t ifu_req, exu_req, mst_req;
  axi_rsp_t ifu_rsp, exu_rsp, mst_rsp;

  assign ifu_req = {ifu_awvalid, ifu_awaddr, ifu_awid, ifu_awlen, ifu_awsize, ifu_awburst,
                    ifu_wvalid, ifu_wdata, ifu_wstrb, ifu_wlast, ifu_bready,
                    ifu_arvalid, ifu_araddr, ifu_arid, ifu_arlen, ifu_arsize, ifu_arburst,
                    ifu_rready};
  assign exu_req = {exu_awvalid, exu_awaddr, exu_awid, exu_awlen, exu_awsize, exu_awburst,
                    exu_wvalid, exu_wdata, exu_wstrb, exu_wlast, exu_bready,
                    exu_arvalid, exu_araddr, exu_arid, exu_arlen, exu_arsize, exu_arburst,
                    exu_rready};
  assign {io_master_awvalid, io_master_awaddr, io_master_awid, io_master_awlen,
          io_master_awsize, io_master_awburst, io_master_wvalid, io_master_wdata,
          io_master_wstrb, io_master_wlast, io_master_bready, io_master_arvalid,
          io_master_araddr, io_master_arid, io_master_arlen, io_master_arsize,
          io_master_arburst, io_master_rready} = mst_req;

  assign mst_rsp = {io_master_awready, io_master_wready, io_master_bvalid, io_master_bid,
                    io_master_bresp, io_master_arready, io_master_rvalid, io_master_rid,
                    io_master_rdata, io_master_rresp, io_master_rlast};
  assign {ifu_awready, ifu_wready, ifu_bvalid, ifu_bid, ifu_bresp, ifu_arready,
          ifu_rvalid, ifu_rid, ifu_rdata, ifu_rresp, ifu_rlast} = ifu_rsp;
  assign {exu_awready, exu_wready, exu_bvalid, exu_bid, exu_bresp, exu_arready,
          exu_rvalid, exu_rid, exu_rdata, exu_rresp, exu_rlast} = exu_rsp;

  state_e          state_q, state_d;
  dir_e            dir_q, dir_d;
  logic            owner_q, owner_d;
  logic            rr_last_q, rr_last_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_err_q, to_err_d;

  logic req_ifu, req_exu, winner, win_arvalid, done, wd_expire;

  assign req_ifu     = ifu_arvalid | ifu_awvalid;
  assign req_exu     = exu_arvalid | exu_awvalid;
  assign winner      = pick_winner(req_ifu, req_exu, rr_last_q);
  assign win_arvalid = (winner == EXU) ? exu_arvalid : ifu_arvalid;

  // Completion is judged on the downstream handshake so it is owner-agnostic
  assign done = (state_q == BUSY) &&
                ((dir_q == READ)  ? (mst_rsp.rvalid & mst_req.rready & mst_rsp.rlast)
                                  : (mst_rsp.bvalid & mst_req.bready));
  assign wd_expire = WD_EN && (state_q == BUSY) && !done &&
                     (to_cnt_q == TO_W'(TO_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    to_cnt_d  = to_cnt_q;
    to_err_d  = 1'b0;
    if (state_q == IDLE) begin
      to_cnt_d = '0;
      if (req_ifu || req_exu) begin
        state_d   = BUSY;
        owner_d   = winner;
        rr_last_d = winner;
        dir_d     = win_arvalid ? READ : WRITE;
      end
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
      if (done) begin
        state_d = IDLE;
      end else if (wd_expire) begin
        state_d  = IDLE;
        to_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dir_q     <= READ;
      owner_q   <= IFU;
      rr_last_q <= EXU;
      to_cnt_q  <= '0;
      to_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      to_cnt_q  <= to_cnt_d;
      to_err_q  <= to_err_d;
    end
  end

  assign busy   = (state_q == BUSY);
  assign owner  = owner_q;
  assign to_err = to_err_q;

  axi_chan_mux u_mux (
    .busy_i    (busy),
    .owner_i   (owner_q),
    .dir_i     (dir_q),
    .ifu_req_i (ifu_req),
    .exu_req_i (exu_req),
    .mst_rsp_i (mst_rsp),
    .mst_req_o (mst_req),
    .ifu_rsp_o (ifu_rsp),
    .exu_rsp_o (exu_rsp)
  );

endmodule
